// File: rtl/sparse_encoder.sv
// Zero-skipping compressor: scans a latched dense vector one element per cycle
// and pushes only non-zero elements, tagged with their position, into a FIFO.
module sparse_encoder #(
    parameter int D_WIDTH = 16,
    parameter int I_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              vec_valid,
    output logic                              vec_ready,
    input  logic [(2**I_WIDTH)*D_WIDTH-1:0]   vec_in,
    input  logic                              fifo_full,
    output logic                              w_en,
    output logic [D_WIDTH-1:0]                data_out,
    output logic [I_WIDTH-1:0]                index_out,
    output logic                              done,
    output logic [I_WIDTH:0]                  nnz_count
);

    localparam int N = 2**I_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [I_WIDTH-1:0]   r_ptr;
    logic [I_WIDTH:0]     r_nnz;
    logic [I_WIDTH:0]     r_nnz_count;
    logic [D_WIDTH-1:0]   r_vec [N];

    logic [D_WIDTH-1:0]   w_elem;
    logic                 w_scan;
    logic                 w_nonzero;
    logic                 w_consume;
    logic                 w_last;

    // Outputs are gated by rst so nothing reaches the FIFO or the done
    // consumer in the cycle the in-flight vector is being discarded.
    assign w_scan    = (r_state == S_SCAN) && !rst;
    assign w_elem    = r_vec[r_ptr];
    assign w_nonzero = |w_elem;
    assign w_consume = w_scan && (!w_nonzero || !fifo_full);
    assign w_last    = (r_ptr == I_WIDTH'(N - 1));

    assign w_en      = w_scan && w_nonzero && !fifo_full;
    assign data_out  = w_scan ? w_elem : '0;
    assign index_out = w_scan ? r_ptr : '0;
    assign vec_ready = (r_state == S_IDLE);
    assign done      = (r_state == S_DONE) && !rst;
    assign nnz_count = r_nnz_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_nnz       <= '0;
            r_nnz_count <= '0;
            for (int i = 0; i < N; i++) begin
                r_vec[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (vec_valid) begin
                        for (int i = 0; i < N; i++) begin
                            r_vec[i] <= vec_in[i*D_WIDTH +: D_WIDTH];
                        end
                        r_ptr   <= '0;
                        r_nnz   <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // A stalled non-zero element leaves ptr and nnz untouched.
                    if (w_consume) begin
                        if (w_en) begin
                            r_nnz <= r_nnz + 1'b1;
                        end
                        if (w_last) begin
                            r_nnz_count <= r_nnz + (I_WIDTH+1)'(w_en);
                            r_state     <= S_DONE;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_encoder.sv
// Self-checking bench for sparse_encoder: per-cycle comparison of FIFO writes,
// stalls, done timing and nnz_count against a vector-level reference model.
module tb_sparse_encoder;

    localparam int D  = 16;
    localparam int IW = 4;
    localparam int N  = 2**IW;
    localparam int VW = N * D;
    localparam int BUDGET = 8 * N;

    logic            clk;
    logic            rst;
    logic            vec_valid;
    logic            vec_ready;
    logic [VW-1:0]   vec_in;
    logic            fifo_full;
    logic            w_en;
    logic [D-1:0]    data_out;
    logic [IW-1:0]   index_out;
    logic            done;
    logic [IW:0]     nnz_count;

    int n_tests;
    int n_fail;

    sparse_encoder #(.D_WIDTH(D), .I_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_in    (vec_in),
        .fifo_full (fifo_full),
        .w_en      (w_en),
        .data_out  (data_out),
        .index_out (index_out),
        .done      (done),
        .nnz_count (nnz_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] rand_vec(input int zero_pct);
        logic [VW-1:0] v;
        logic [D-1:0]  e;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 99) < zero_pct) e = '0;
            else begin
                e = D'($urandom);
                if (e == '0) e = 16'h8000;
            end
            v[i*D +: D] = e;
        end
        return v;
    endfunction

    // Presents a vector in an IDLE cycle; returns just after the accept edge.
    task automatic accept(input logic [VW-1:0] v, input bit hold_valid, input string name);
        vec_valid = 1'b1;
        vec_in    = v;
        @(negedge clk);
        n_tests++;
        if (vec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: vec_ready=%b expected 1", name, vec_ready);
        end
        @(posedge clk);
        #1;
        if (!hold_valid) vec_valid = 1'b0;
    endtask

    // Reference model: walks the vector element by element; a non-zero element
    // with fifo_full high stalls, everything else is consumed in that cycle.
    // mode 0: never full, 1: random full, 2: full during SCAN cycles 3..6.
    task automatic scan_check(input logic [VW-1:0] v, input int mode, input string name);
        int           mptr;
        int           mnnz;
        int           cyc;
        logic         full;
        logic         exp_wen;
        logic [D-1:0] e;
        mptr = 0;
        mnnz = 0;
        cyc  = 0;
        while (mptr < N && cyc < BUDGET) begin
            e = v[mptr*D +: D];
            case (mode)
                0:       full = 1'b0;
                1:       full = (cyc < BUDGET/2) && ($urandom_range(0, 2) == 0);
                default: full = (cyc >= 2 && cyc <= 5);
            endcase
            fifo_full = full;
            exp_wen   = (e != '0) && !full;
            @(negedge clk);
            n_tests++;
            if (w_en !== exp_wen) begin
                n_fail++;
                $display("FAIL %s w_en ptr=%0d cyc=%0d: got %b expected %b", name, mptr, cyc, w_en, exp_wen);
            end
            if (e != '0) begin
                n_tests++;
                if (index_out !== mptr[IW-1:0] || (exp_wen && data_out !== e)) begin
                    n_fail++;
                    $display("FAIL %s index/data cyc=%0d: got idx=%0d data=%h expected idx=%0d data=%h",
                             name, cyc, index_out, data_out, mptr, e);
                end
            end
            n_tests++;
            if (done !== 1'b0 || vec_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s scan ctrl cyc=%0d: done=%b vec_ready=%b expected 0/0", name, cyc, done, vec_ready);
            end
            @(posedge clk);
            #1;
            if (!(e != '0 && full)) begin
                if (e != '0) mnnz++;
                mptr++;
            end
            cyc++;
        end
        fifo_full = 1'b0;
        n_tests++;
        if (mptr < N) begin
            n_fail++;
            $display("FAIL %s timeout: model ptr=%0d after %0d cycles", name, mptr, cyc);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || nnz_count !== mnnz[IW:0] || w_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done cycle %0d: done=%b nnz=%0d w_en=%b expected 1/%0d/0",
                     name, cyc, done, nnz_count, w_en, mnnz);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (vec_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after done: vec_ready=%b done=%b expected 1/0", name, vec_ready, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (w_en !== 1'b0 || vec_ready !== 1'b1 || data_out !== '0 || index_out !== '0
            || done !== 1'b0 || nnz_count !== '0) begin
            n_fail++;
            $display("FAIL reset: w_en=%b rdy=%b data=%h idx=%0d done=%b nnz=%0d expected 0/1/0/0/0/0",
                     w_en, vec_ready, data_out, index_out, done, nnz_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_all_zero();
        logic [VW-1:0] v;
        v = '0;
        accept(v, 1'b0, "all_zero");
        scan_check(v, 0, "all_zero");
    endtask

    task automatic test_ramp();
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*D +: D] = D'(i);
        accept(v, 1'b0, "ramp");
        scan_check(v, 0, "ramp");
    endtask

    task automatic test_stall_window();
        logic [VW-1:0] v;
        v = '1;
        accept(v, 1'b0, "stall_window");
        scan_check(v, 2, "stall_window");
    endtask

    task automatic test_last_only();
        logic [VW-1:0] v;
        v = '0;
        v[(N-1)*D +: D] = 16'h0001;
        accept(v, 1'b0, "last_only");
        scan_check(v, 0, "last_only");
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] va;
        logic [VW-1:0] vb;
        for (int i = 0; i < N; i++) begin
            va[i*D +: D] = (i % 3 == 0) ? 16'h0000 : (16'hA000 | D'(i));
            vb[i*D +: D] = (i % 2 == 0) ? 16'h0000 : (16'hB000 | D'(i));
        end
        accept(va, 1'b1, "b2b_first");
        vec_in = vb;
        scan_check(va, 1, "b2b_first");
        accept(vb, 1'b0, "b2b_second");
        scan_check(vb, 0, "b2b_second");
    endtask

    task automatic test_reset_mid_scan();
        logic [VW-1:0] v;
        logic [VW-1:0] v2;
        logic          saw_bad;
        for (int i = 0; i < N; i++) v[i*D +: D] = D'(i + 1);
        accept(v, 1'b0, "rst_mid");
        fifo_full = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (w_en !== 1'b1 || index_out !== IW'(k)) begin
                n_fail++;
                $display("FAIL rst_mid write %0d: w_en=%b idx=%0d expected 1/%0d", k, w_en, index_out, k);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if (vec_ready !== 1'b1 || w_en !== 1'b0 || index_out !== '0 || done !== 1'b0 || nnz_count !== '0) begin
            n_fail++;
            $display("FAIL rst_mid after reset: rdy=%b w_en=%b idx=%0d done=%b nnz=%0d expected 1/0/0/0/0",
                     vec_ready, w_en, index_out, done, nnz_count);
        end
        saw_bad = 1'b0;
        repeat (N + 4) begin
            @(negedge clk);
            if (done !== 1'b0 || w_en !== 1'b0) saw_bad = 1'b1;
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (saw_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid idle: activity after reset=%b expected 0", saw_bad);
        end
        v2 = rand_vec(40);
        v2[15:0] = 16'h1234;
        accept(v2, 1'b0, "rst_fresh");
        scan_check(v2, 0, "rst_fresh");
    endtask

    task automatic test_random();
        logic [VW-1:0] v;
        for (int t = 0; t < 12; t++) begin
            v = rand_vec($urandom_range(0, 90));
            accept(v, 1'b0, "random");
            scan_check(v, 1, "random");
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        vec_valid = 1'b0;
        vec_in    = '0;
        fifo_full = 1'b0;
        test_reset();
        test_all_zero();
        test_ramp();
        test_stall_window();
        test_last_only();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sparse_encoder.md
Name: sparse_encoder

Overview:
- Zero-skipping compressor that sits directly upstream of the (value, index) FIFO.
- Accepts one dense activation vector of N = 2**I_WIDTH elements per transaction.
- Scans the vector one element per cycle and pushes only non-zero elements, tagged with their position, into the FIFO write port.
- Honours FIFO back-pressure and reports the non-zero count when each vector is finished.

Parameters:
D_WIDTH, 16, element width in bits; must match the FIFO data width.
I_WIDTH, 4, index width in bits; vector length N = 2**I_WIDTH.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
vec_valid  input  1  dense vector on vec_in is valid.
vec_ready  output  1  encoder can accept a vector (high only in IDLE).
vec_in  input  N*D_WIDTH  dense vector; element i is at bits [i*D_WIDTH +: D_WIDTH].
fifo_full  input  1  FIFO full flag; no write may be issued while it is high.
w_en  output  1  FIFO write enable, one element per cycle.
data_out  output  D_WIDTH  non-zero element value, valid when w_en is high.
index_out  output  I_WIDTH  element position 0..N-1, valid when w_en is high.
done  output  1  one-cycle pulse when the vector is fully processed.
nnz_count  output  I_WIDTH+1  number of elements written for the last vector; valid while done is high, held until the next accept.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- State machine has three states: IDLE, SCAN, DONE. Reset state is IDLE.
- Reset values: ptr=0, nnz=0, nnz_count=0, vector register=0, done=0.
- Resulting outputs under reset: w_en=0, vec_ready=1, data_out=0, index_out=0.
- IDLE:
  - vec_ready=1.
  - On vec_valid&vec_ready: latch vec_in into an internal register array, ptr<=0, nnz<=0, go to SCAN.
  - vec_in is sampled only in the accept cycle.
- SCAN: vec_ready=0. Let e = element[ptr].
  - e==0: no write, ptr<=ptr+1.
  - e!=0 and fifo_full==0:
    - w_en=1, data_out=e, index_out=ptr.
    - nnz<=nnz+1, ptr<=ptr+1.
  - e!=0 and fifo_full==1: w_en=0; ptr and nnz hold (stall). Element order is always preserved.
  - When the element at ptr==N-1 is consumed (skipped or written): nnz_count<=final nnz, go to DONE.
- Output timing:
  - w_en, data_out and index_out are combinational from state, ptr, the vector register and fifo_full.
  - This lets the FIFO capture the write on the same clock edge, with no overflow window.
  - Outside SCAN: w_en=0, data_out=0, index_out=0.
- Zero test is an exact all-bits-zero compare; negative values count as non-zero.
- DONE: done=1 for exactly one cycle, nnz_count is valid, next state IDLE.
- Latency:
  - With no stalls, a vector accepted at edge T produces SCAN cycles T+1..T+N, done at cycle T+N+1, and vec_ready again at T+N+2.
  - Each stall cycle adds one cycle.
- Width rules:
  - nnz counts from 0 to N inclusive (all non-zero), hence I_WIDTH+1 bits.
  - ptr is I_WIDTH bits and never wraps within a vector.
- Boundary conditions:
  - vec_valid while not in IDLE is ignored; no latch, no effect.
  - fifo_full may toggle on any cycle and takes effect in the same cycle.
  - rst mid-SCAN or in DONE: next state IDLE, the in-flight vector is discarded, done is not pulsed, nnz_count=0.
  - Writes already accepted by the FIFO are not recalled.

Test Plan:
1. All-zero vector, fifo_full=0 -> w_en never high; done pulses 17 cycles after the accept edge with nnz_count=0; vec_ready returns the next cycle.
2. Vector with element i = i (0..15) -> 15 writes, index_out 1..15, data_out equal to index_out; element 0 skipped; nnz_count=15.
3. All elements 0xFFFF, fifo_full high for cycles 3-6 of SCAN -> w_en low for exactly those 4 cycles with index held; 16 in-order writes; done at accept+21; nnz_count=16.
4. Only element 15 = 0x0001 -> single write with index_out=15, data_out=1, in the last SCAN cycle, immediately followed by done.
5. vec_valid held high continuously with two different vectors -> second accepted only in the IDLE cycle after done; no element of the second vector appears before the first done.
6. rst asserted after 5 writes -> next cycle state IDLE, w_en=0, vec_ready=1, no done pulse; a fresh vector then encodes correctly from index 0.
